// File: rtl/alu_req_arbiter_if.sv
// Bus bundle for alu_req_arbiter: requester side, shared ALU side and response side.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface alu_req_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [32*NREQ-1:0]   req_a;
    logic [32*NREQ-1:0]   req_b;
    logic [3*NREQ-1:0]    req_op;
    logic [31:0]          alu_a;
    logic [31:0]          alu_b;
    logic [2:0]           alu_ctrl;
    logic [31:0]          alu_result;
    logic                 alu_zero;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic [31:0]          rsp_result;
    logic                 rsp_zero;
    logic                 rsp_err;
    logic [CNT_W-1:0]     op_count;

    modport slave (
        input  req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
        output req_ready, alu_a, alu_b, alu_ctrl,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, op_count
    );

    modport master (
        output req_valid, req_a, req_b, req_op, alu_result, alu_zero, rsp_ready,
        input  req_ready, alu_a, alu_b, alu_ctrl,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, op_count
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters,
// with a one-entry registered response slot and an accepted-operation counter.
module alu_req_arbiter #(
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_req_arbiter_if.slave bus
);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NREQ - 1);
    localparam logic [ID_W-1:0]  ONE_ID  = ID_W'(1);
    localparam logic [ID_W:0]    NREQ_W  = (ID_W + 1)'(NREQ);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
    localparam logic [2:0]       OP_AND  = 3'b000;
    localparam logic [2:0]       OP_MAX  = 3'b100;

    // Codes above XOR have no ALU function and are flagged as errors.
    function automatic logic op_illegal(input logic [2:0] op);
        return (op > OP_MAX);
    endfunction

    logic [31:0]      a_arr_s  [NREQ];
    logic [31:0]      b_arr_s  [NREQ];
    logic [2:0]       op_arr_s [NREQ];
    logic             free_s;
    logic             grant_s;
    logic             hit_s;
    logic [ID_W:0]    scan_sum_s;
    logic [ID_W-1:0]  scan_idx_s;
    logic [ID_W-1:0]  win_s;
    logic [2:0]       win_op_s;
    logic             illegal_s;
    logic [ID_W-1:0]  rr_ptr_r;
    logic             rsp_valid_r;
    logic [ID_W-1:0]  rsp_id_r;
    logic [31:0]      rsp_result_r;
    logic             rsp_zero_r;
    logic             rsp_err_r;
    logic [CNT_W-1:0] op_count_r;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr_s[g]  = bus.req_a[32*g +: 32];
        assign b_arr_s[g]  = bus.req_b[32*g +: 32];
        assign op_arr_s[g] = bus.req_op[3*g +: 3];
    end

    assign free_s = !rsp_valid_r || bus.rsp_ready;

    // Scan from rr_ptr upward (mod NREQ); the first valid requester wins.
    always_comb begin
        grant_s    = 1'b0;
        hit_s      = 1'b0;
        win_s      = '0;
        scan_sum_s = '0;
        scan_idx_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum_s = {1'b0, rr_ptr_r} + (ID_W + 1)'(k);
            scan_sum_s = (scan_sum_s >= NREQ_W) ? (scan_sum_s - NREQ_W) : scan_sum_s;
            scan_idx_s = scan_sum_s[ID_W-1:0];
            hit_s      = free_s && !grant_s && bus.req_valid[scan_idx_s];
            win_s      = hit_s ? scan_idx_s : win_s;
            grant_s    = grant_s || hit_s;
        end
    end

    assign win_op_s  = op_arr_s[win_s];
    assign illegal_s = op_illegal(win_op_s);

    // ALU operands follow the winner; illegal codes run the ALU as a harmless AND.
    always_comb begin
        bus.req_ready = '0;
        bus.alu_a     = 32'd0;
        bus.alu_b     = 32'd0;
        bus.alu_ctrl  = OP_AND;
        if (grant_s) begin
            bus.req_ready = {{(NREQ-1){1'b0}}, 1'b1} << win_s;
            bus.alu_a     = a_arr_s[win_s];
            bus.alu_b     = b_arr_s[win_s];
            bus.alu_ctrl  = illegal_s ? OP_AND : win_op_s;
        end else begin
            bus.req_ready = '0;
        end
    end

    // Response slot, round-robin pointer and accept counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r     <= '0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= '0;
            rsp_result_r <= 32'd0;
            rsp_zero_r   <= 1'b0;
            rsp_err_r    <= 1'b0;
            op_count_r   <= '0;
        end else if (grant_s) begin
            rr_ptr_r     <= (win_s == LAST_ID) ? '0 : (win_s + ONE_ID);
            op_count_r   <= op_count_r + ONE_CNT;
            rsp_valid_r  <= 1'b1;
            rsp_id_r     <= win_s;
            rsp_result_r <= illegal_s ? 32'd0 : bus.alu_result;
            rsp_zero_r   <= illegal_s ? 1'b0 : bus.alu_zero;
            rsp_err_r    <= illegal_s;
        end else if (rsp_valid_r && bus.rsp_ready) begin
            rsp_valid_r  <= 1'b0;
        end else begin
            rsp_valid_r  <= rsp_valid_r;
        end
    end

    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_zero   = rsp_zero_r;
    assign bus.rsp_err    = rsp_err_r;
    assign bus.op_count   = op_count_r;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed-vector bench for alu_req_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares each response the DUT hands over.
module tb_alu_req_arbiter;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int CNT_W = 16;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] result;
        logic        zero;
        logic        err;
    } rsp_t;

    logic        clk;
    logic        reset;
    int          n_pass;
    int          n_total;
    logic [15:0] exp_cnt;
    rsp_t        exp_q[$];
    rsp_t        mon_e;

    alu_req_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

    alu_req_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference combinational ALU shared through the arbiter.
    always_comb begin
        case (bus.alu_ctrl)
            3'b000:  bus.alu_result = bus.alu_a & bus.alu_b;
            3'b001:  bus.alu_result = bus.alu_a | bus.alu_b;
            3'b010:  bus.alu_result = bus.alu_a + bus.alu_b;
            3'b011:  bus.alu_result = bus.alu_a - bus.alu_b;
            3'b100:  bus.alu_result = bus.alu_a ^ bus.alu_b;
            default: bus.alu_result = 32'd0;
        endcase
        bus.alu_zero = (bus.alu_result == 32'd0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [1:0] id, input logic [31:0] res, input logic z, input logic e);
        rsp_t r;
        r.id = id; r.result = res; r.zero = z; r.err = e;
        exp_q.push_back(r);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.req_valid[i]      = 1'b1;
        bus.req_a[32*i +: 32] = a;
        bus.req_b[32*i +: 32] = b;
        bus.req_op[3*i +: 3]  = op;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handed-over response must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", {31'd0, bus.rsp_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id",     {30'd0, bus.rsp_id}, {30'd0, mon_e.id});
                chk("rsp_result", bus.rsp_result, mon_e.result);
                chk("rsp_zero",   {31'd0, bus.rsp_zero}, {31'd0, mon_e.zero});
                chk("rsp_err",    {31'd0, bus.rsp_err}, {31'd0, mon_e.err});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int          gnt_seq [5];
        logic [31:0] res_tab [4];
        gnt_seq = '{0, 1, 2, 3, 0};
        res_tab = '{32'd3, 32'd4, 32'h30, 32'hFF};
        n_pass = 0; n_total = 0; exp_cnt = 16'd0;
        reset = 1'b1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = '0;
        bus.req_a = '0; bus.req_b = '0; bus.req_op = '0;
        step(); step();
        chk("reset_rsp_valid",  {31'd0, bus.rsp_valid}, 32'd0);
        chk("reset_rsp_id",     {30'd0, bus.rsp_id}, 32'd0);
        chk("reset_rsp_result", bus.rsp_result, 32'd0);
        chk("reset_rsp_flags",  {30'd0, bus.rsp_zero, bus.rsp_err}, 32'd0);
        chk("reset_op_count",   {16'd0, bus.op_count}, 32'd0);
        reset = 1'b0;

        // single request: 5 - 3 on requester 2
        step();
        set_req(2, 32'd5, 32'd3, 3'b011);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t1_req_ready", {28'd0, bus.req_ready}, 32'h4);
        push(2'd2, 32'd2, 1'b0, 1'b0);
        step(); exp_cnt++;
        bus.req_valid = '0;
        @(negedge clk);
        chk("t1_op_count", {16'd0, bus.op_count}, {16'd0, exp_cnt});
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_cnt = 16'd0;

        // all four requesters valid: rotation 0,1,2,3,0
        set_req(0, 32'd1,   32'd2,   3'b010);
        set_req(1, 32'd7,   32'd3,   3'b011);
        set_req(2, 32'hF0,  32'h3C,  3'b000);
        set_req(3, 32'hF0,  32'h0F,  3'b001);
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            chk("t2_rr_grant", {28'd0, bus.req_ready}, 32'd1 << gnt_seq[g]);
            push(gnt_seq[g][1:0], res_tab[gnt_seq[g]], 1'b0, 1'b0);
            step(); exp_cnt++;
        end

        // backpressure: held response from requester 0 (result 3)
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        set_req(1, 32'd9, 32'd4, 3'b011);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("t3_stall_ready",  {28'd0, bus.req_ready}, 32'd0);
            chk("t3_stall_valid",  {31'd0, bus.rsp_valid}, 32'd1);
            chk("t3_stall_id",     {30'd0, bus.rsp_id}, 32'd0);
            chk("t3_stall_result", bus.rsp_result, 32'd3);
            chk("t3_stall_flags",  {30'd0, bus.rsp_zero, bus.rsp_err}, 32'd0);
            chk("t3_stall_count",  {16'd0, bus.op_count}, {16'd0, exp_cnt});
            step();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_release_grant", {28'd0, bus.req_ready}, 32'h2);
        push(2'd1, 32'd5, 1'b0, 1'b0);
        step(); exp_cnt++;
        bus.req_valid = '0;

        // illegal op code 110
        set_req(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b110);
        @(negedge clk);
        chk("t4_req_ready", {28'd0, bus.req_ready}, 32'h1);
        chk("t4_alu_ctrl",  {29'd0, bus.alu_ctrl}, 32'd0);
        push(2'd0, 32'd0, 1'b0, 1'b1);
        step(); exp_cnt++;
        bus.req_valid = '0;
        @(negedge clk);
        chk("t4_op_count", {16'd0, bus.op_count}, {16'd0, exp_cnt});
        step();

        // zero flag via XOR of equal operands
        set_req(3, 32'h12345678, 32'h12345678, 3'b100);
        @(negedge clk);
        chk("t5_req_ready", {28'd0, bus.req_ready}, 32'h8);
        push(2'd3, 32'd0, 1'b1, 1'b0);
        step(); exp_cnt++;
        bus.req_valid = '0;

        // preload counter to all-ones, then wrap
        set_req(0, 32'd0, 32'd0, 3'b000);
        while (exp_cnt != 16'hFFFF) begin
            @(negedge clk);
            push(2'd0, 32'd0, 1'b1, 1'b0);
            step(); exp_cnt++;
        end
        @(negedge clk);
        chk("t6_op_count_max", {16'd0, bus.op_count}, 32'hFFFF);
        push(2'd0, 32'd0, 1'b1, 1'b0);
        step(); exp_cnt++;
        bus.req_valid = '0;
        set_req(2, 32'd1, 32'd1, 3'b010);
        @(negedge clk);
        chk("t6_op_count_wrap", {16'd0, bus.op_count}, {16'd0, exp_cnt});
        chk("t6_req_ready", {28'd0, bus.req_ready}, 32'h4);
        push(2'd2, 32'd2, 1'b0, 1'b0);
        step(); exp_cnt++;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;

        // asynchronous reset while a response is held
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("t6_async_op_count",  {16'd0, bus.op_count}, 32'd0);
        exp_q.delete();
        exp_cnt = 16'd0;
        step();
        reset = 1'b0;
        set_req(1, 32'd8, 32'd8, 3'b011);
        set_req(3, 32'd3, 32'd5, 3'b001);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t6_ptr_after_reset", {28'd0, bus.req_ready}, 32'h2);
        push(2'd1, 32'd0, 1'b1, 1'b0);
        step(); exp_cnt++;
        bus.req_valid = '0;
        @(negedge clk);
        chk("t6_op_count_after_reset", {16'd0, bus.op_count}, {16'd0, exp_cnt});
        step(); step();
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
